debug_unit: RTL and testbench

Host-side debug controller for the five-stage MIPS pipeline. It sits downstream of the `Pipeline` top level and consumes its exported observation buses: fetch PC, the register file image and the data-memory image. It accepts one-byte commands from a UART receiver and gates the pipeline clock enable for free-run or single-step execution. When execution stops, it streams a fixed-length state dump to a UART transmitter over a valid/ready byte handshake.

---
 rtl/debug_pkg.sv | 20 ++
 rtl/debug_frame_mux.sv | 72 +++++++
 rtl/debug_unit.sv | 126 ++++++++++++
 tb/tb_debug_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared command codes, frame length and FSM state type for the pipeline
// debug controller.
package debug_pkg;

    localparam logic [7:0] CMD_RUN     = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP    = 8'h73;  // 's'
    localparam logic [7:0] CMD_DUMP    = 8'h64;  // 'd'
    localparam logic [5:0] HALT_OPCODE = 6'h3F;

    // 2 (pc) + 4*32 (regs) + 4*10 (mem) + 4 (cycle counter)
    localparam int DUMP_LEN = 174;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DUMP = 2'd3
    } state_t;

endpackage

// File: rtl/debug_frame_mux.sv
// Maps a dump byte index onto the live observation buses: pc, register file,
// data memory and cycle counter, every field most-significant byte first.
module debug_frame_mux
    import debug_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int NREGS     = 32,
    parameter int MEM_WORDS = 10
) (
    input  logic [7:0]              i_byte_idx,
    input  logic [PC_W-1:0]         i_pc,
    input  logic [32*NREGS-1:0]     i_regs,
    input  logic [32*MEM_WORDS-1:0] i_mem,
    input  logic [31:0]             i_cycles,
    output logic [7:0]              o_byte
);

    localparam logic [7:0] REG_BASE = 8'd2;
    localparam logic [7:0] MEM_BASE = 8'(2 + 4 * NREGS);
    localparam logic [7:0] CNT_BASE = 8'(2 + 4 * NREGS + 4 * MEM_WORDS);
    localparam int REG_OW = $clog2(NREGS) + 2;
    localparam int MEM_OW = $clog2(MEM_WORDS) + 2;

    logic [31:0]       w_regs [NREGS];
    logic [31:0]       w_mem  [MEM_WORDS];
    logic [15:0]       w_pc16;
    logic [REG_OW-1:0] w_reg_off;
    logic [MEM_OW-1:0] w_mem_off;
    logic [1:0]        w_cnt_lane;
    logic [31:0]       w_word;
    logic [1:0]        w_lane;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        assign w_regs[gi] = i_regs[32*gi +: 32];
    end
    for (genvar gi = 0; gi < MEM_WORDS; gi++) begin : g_mem
        assign w_mem[gi] = i_mem[32*gi +: 32];
    end

    assign w_pc16     = 16'(i_pc);
    assign w_reg_off  = REG_OW'(i_byte_idx - REG_BASE);
    assign w_mem_off  = MEM_OW'(i_byte_idx - MEM_BASE);
    assign w_cnt_lane = 2'(i_byte_idx - CNT_BASE);

    // Select the 32-bit field holding this byte, then the lane within it
    // (lane 0 = bits 31:24). The pc field occupies lanes 2..3 only.
    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        w_word = i_cycles;
        w_lane = w_cnt_lane;
        if (i_byte_idx < REG_BASE) begin
            w_word = {16'd0, w_pc16};
            w_lane = {1'b1, i_byte_idx[0]};
        end else if (i_byte_idx < MEM_BASE) begin
            w_word = w_regs[w_reg_off[REG_OW-1:2]];
            w_lane = w_reg_off[1:0];
        end else if (i_byte_idx < CNT_BASE) begin
            w_word = w_mem[w_mem_off[MEM_OW-1:2]];
            w_lane = w_mem_off[1:0];
        end
    end

    always_comb begin
        case (w_lane)
            2'd0:    o_byte = w_word[31:24];
            2'd1:    o_byte = w_word[23:16];
            2'd2:    o_byte = w_word[15:8];
            default: o_byte = w_word[7:0];
        endcase
    end

endmodule

// File: rtl/debug_unit.sv
// Debug controller: command FSM, pipeline clock enable, cycle counter and a
// byte-serial state dump over a valid/ready handshake.
module debug_unit
    import debug_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int NREGS     = 32,
    parameter int MEM_WORDS = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [31:0]             instruction,
    input  logic [PC_W-1:0]         pc_in,
    input  logic [32*NREGS-1:0]     regs_in,
    input  logic [32*MEM_WORDS-1:0] mem_in,
    output logic                    pipe_enable,
    output logic                    halted,
    output logic                    busy
);

    localparam logic [7:0] LAST_IDX = 8'(DUMP_LEN - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_pipe_enable;
    logic        r_halted;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_idx;
    logic [31:0] r_cycles;
    logic [7:0]  w_frame_byte;
    logic        w_halt_op;
    logic        w_xfer;
    logic        w_last;
    logic        w_set_halt;
    logic        w_unused;

    assign w_halt_op = (instruction[31:26] == HALT_OPCODE);
    assign w_unused  = ^instruction[25:0];
    assign w_xfer    = r_tx_valid & tx_ready;
    assign w_last    = (r_idx == LAST_IDX);

    always_comb begin
        w_next_state = r_state;
        w_set_halt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_RUN:  if (!r_halted) w_next_state = RUN;
                        CMD_STEP: if (!r_halted) w_next_state = STEP;
                        CMD_DUMP: w_next_state = DUMP;
                        default:  w_next_state = IDLE;
                    endcase
                end
            end
            RUN: begin
                if (r_pipe_enable && w_halt_op) begin
                    w_next_state = DUMP;
                    w_set_halt   = 1'b1;
                end
            end
            STEP: begin
                w_next_state = DUMP;
                w_set_halt   = w_halt_op;
            end
            default: begin
                if (w_xfer && w_last) w_next_state = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pipe_enable <= 1'b0;
            r_halted      <= 1'b0;
            r_cycles      <= '0;
            r_idx         <= '0;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= '0;
        end else begin
            r_state       <= w_next_state;
            r_pipe_enable <= (w_next_state == RUN) || (w_next_state == STEP);
            if (w_set_halt) r_halted <= 1'b1;
            if (r_pipe_enable) r_cycles <= r_cycles + 32'd1;

            if (r_state != DUMP && w_next_state == DUMP) r_idx <= '0;
            else if (w_xfer) r_idx <= r_idx + 8'd1;

            // Present a byte only while idle-handed, so at most one per two cycles.
            if (w_xfer) begin
                r_tx_valid <= 1'b0;
            end else if (r_state == DUMP && !r_tx_valid) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_frame_byte;
            end
        end
    end

    debug_frame_mux #(
        .PC_W      (PC_W),
        .NREGS     (NREGS),
        .MEM_WORDS (MEM_WORDS)
    ) u_frame_mux (
        .i_byte_idx (r_idx),
        .i_pc       (pc_in),
        .i_regs     (regs_in),
        .i_mem      (mem_in),
        .i_cycles   (r_cycles),
        .o_byte     (w_frame_byte)
    );

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign pipe_enable = r_pipe_enable;
    assign halted      = r_halted;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_debug_unit.sv
// Randomized self-checking bench for debug_unit against a field-level frame
// model and a count of intended pipeline-enable cycles.
module tb_debug_unit;
    import debug_pkg::*;

    localparam int PC_W      = 10;
    localparam int NREGS     = 32;
    localparam int MEM_WORDS = 10;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [31:0]             instruction;
    logic [PC_W-1:0]         pc_in;
    logic [32*NREGS-1:0]     regs_in;
    logic [32*MEM_WORDS-1:0] mem_in;
    logic                    pipe_enable;
    logic                    halted;
    logic                    busy;

    logic [31:0]     m_regs [NREGS];
    logic [31:0]     m_mem  [MEM_WORDS];
    logic [PC_W-1:0] m_pc;
    int unsigned     m_cycles;
    logic [7:0]      exp_frame [DUMP_LEN];
    logic [7:0]      got_frame [DUMP_LEN];
    int              n_checks = 0;
    int              n_errors = 0;
    int              en_cnt;

    always #5 clk = ~clk;

    debug_unit #(
        .PC_W      (PC_W),
        .NREGS     (NREGS),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .instruction (instruction),
        .pc_in       (pc_in),
        .regs_in     (regs_in),
        .mem_in      (mem_in),
        .pipe_enable (pipe_enable),
        .halted      (halted),
        .busy        (busy)
    );

    always_comb begin
        regs_in = '0;
        mem_in  = '0;
        pc_in   = m_pc;
        for (int i = 0; i < NREGS; i++) regs_in[32*i +: 32] = m_regs[i];
        for (int i = 0; i < MEM_WORDS; i++) mem_in[32*i +: 32] = m_mem[i];
    end

    // Counts cycles with the pipeline enabled since the last reset.
    always @(negedge clk or posedge reset) begin
        if (reset) en_cnt <= 0;
        else if (pipe_enable) en_cnt <= en_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void randomize_state();
        m_pc = PC_W'($urandom);
        for (int i = 0; i < NREGS; i++) m_regs[i] = $urandom;
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = $urandom;
        instruction = {6'($urandom_range(0, 62)), 26'($urandom)};
    endfunction

    // Frame built field by field, big-endian, from the model state.
    function automatic void build_frame();
        logic [7:0]  q [$];
        logic [15:0] pc16;
        pc16 = 16'(m_pc);
        q.push_back(pc16[15:8]);
        q.push_back(pc16[7:0]);
        for (int r = 0; r < NREGS; r++)
            for (int b = 3; b >= 0; b--) q.push_back(8'(m_regs[r] >> (8 * b)));
        for (int m = 0; m < MEM_WORDS; m++)
            for (int b = 3; b >= 0; b--) q.push_back(8'(m_mem[m] >> (8 * b)));
        for (int b = 3; b >= 0; b--) q.push_back(8'(m_cycles >> (8 * b)));
        for (int i = 0; i < DUMP_LEN; i++) exp_frame[i] = q[i];
    endfunction

    function automatic logic [31:0] got_word(input int base);
        return {got_frame[base], got_frame[base+1], got_frame[base+2], got_frame[base+3]};
    endfunction

    // Leaves the bench at the falling edge right after the accepting edge.
    task automatic send_cmd(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Called at the falling edge right after DUMP entry.
    task automatic collect_dump(input bit rand_ready, input int inject_cyc,
                                input logic [7:0] inj_byte, input int abort_at);
        int         nrx = 0;
        int         cyc = 0;
        int         busy_cyc = 0;
        bit         hold = 1'b0;
        logic [7:0] hold_data = '0;
        bit         saw_enable = 1'b0;
        bit         extra = 1'b0;
        build_frame();
        check("txv_first", 32'(tx_valid), 32'd0);
        while (nrx < DUMP_LEN && cyc < 4000) begin
            if (nrx == abort_at) begin
                tx_ready = 1'b0;
                rx_valid = 1'b0;
                return;
            end
            if (busy) busy_cyc++;
            if (pipe_enable) saw_enable = 1'b1;
            if (hold) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, hold_data});
            rx_valid = (cyc == inject_cyc);
            rx_data  = inj_byte;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready) begin
                check("frame_byte", 32'(tx_data), 32'(exp_frame[nrx]));
                got_frame[nrx] = tx_data;
                nrx++;
            end
            hold      = tx_valid && !tx_ready;
            hold_data = tx_data;
            @(negedge clk);
            cyc++;
        end
        rx_valid = 1'b0;
        check("dump_bytes", 32'(nrx), 32'(DUMP_LEN));
        check("dump_done", 32'(busy), 32'd0);
        if (!rand_ready) check("dump_cycles", 32'(busy_cyc), 32'd348);
        tx_ready = 1'b1;
        repeat (4) begin
            if (tx_valid) extra = 1'b1;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("no_extra_byte", 32'(extra), 32'd0);
        check("frozen", 32'(saw_enable), 32'd0);
    endtask

    // HALT is presented so that the k-th enabled edge is the one that sees it.
    task automatic run_to_halt(input int k);
        send_cmd(CMD_RUN);
        check("run_enable", 32'(pipe_enable), 32'd1);
        repeat (k - 1) @(negedge clk);
        check("run_still_enabled", 32'(pipe_enable), 32'd1);
        instruction = HALT_WORD;
        @(negedge clk);
        instruction = NOP_WORD;
        check("halt_stop", 32'(pipe_enable), 32'd0);
        check("halted_set", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd1);
        m_cycles += 32'(k);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {29'd0, busy, pipe_enable, tx_valid}, 32'd0);
    endtask

    initial begin
        int k;
        reset       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        tx_ready    = 1'b0;
        m_cycles    = 0;
        randomize_state();
        instruction = NOP_WORD;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pipe_enable", 32'(pipe_enable), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // First dump with known pc and r1.
        m_regs[1] = 32'h1122_3344;
        m_pc      = 10'h005;
        send_cmd(CMD_DUMP);
        check("dump_enter_busy", 32'(busy), 32'd1);
        collect_dump(1'b0, -1, 8'h00, -1);
        check("pc_hi", 32'(got_frame[0]), 32'h00);
        check("pc_lo", 32'(got_frame[1]), 32'h05);
        check("r1_word", got_word(6), 32'h1122_3344);
        check("cnt_zero", got_word(170), 32'd0);
        #1 check("no_enable_dump", 32'(en_cnt), 32'd0);

        // Unknown command byte in IDLE.
        send_cmd(8'h41);
        check_idle_outputs("junk_ignored");

        // Three single steps, each drained by its dump.
        for (int s = 0; s < 3; s++) begin
            randomize_state();
            send_cmd(CMD_STEP);
            check("step_enable", 32'(pipe_enable), 32'd1);
            @(negedge clk);
            check("step_one_cycle", 32'(pipe_enable), 32'd0);
            m_cycles++;
            collect_dump(1'b1, -1, 8'h00, -1);
        end
        check("step_cnt3", got_word(170), 32'd3);
        #1 check("step_enable_total", 32'(en_cnt), 32'(m_cycles));

        // 'c' arriving mid-dump is dropped.
        randomize_state();
        send_cmd(CMD_DUMP);
        collect_dump(1'b1, int'($urandom_range(10, 200)), CMD_RUN, -1);
        check_idle_outputs("middump_cmd_ignored");

        // Fresh counter, free run until HALT after 20 enabled cycles.
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        m_cycles = 0;
        randomize_state();
        run_to_halt(20);
        collect_dump(1'b1, -1, 8'h00, -1);
        check("halt_cnt20", got_word(170), 32'd20);

        // Halted: run and step refused, dump still honoured.
        send_cmd(CMD_RUN);
        check_idle_outputs("halted_run_ignored");
        send_cmd(CMD_STEP);
        check_idle_outputs("halted_step_ignored");
        randomize_state();
        send_cmd(CMD_DUMP);
        collect_dump(1'b1, -1, 8'h00, -1);
        check("halted_still", 32'(halted), 32'd1);

        // Reset in the middle of a dump.
        randomize_state();
        send_cmd(CMD_DUMP);
        collect_dump(1'b1, -1, 8'h00, 50);
        reset = 1'b1;
        #1;
        check("abort_pipe_enable", 32'(pipe_enable), 32'd0);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_tx_data", 32'(tx_data), 32'd0);
        check("abort_halted", 32'(halted), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        m_cycles = 0;
        @(negedge clk);
        randomize_state();
        send_cmd(CMD_DUMP);
        collect_dump(1'b0, -1, 8'h00, -1);

        // Random-length run to HALT.
        k = int'($urandom_range(1, 40));
        randomize_state();
        run_to_halt(k);
        collect_dump(1'b1, -1, 8'h00, -1);
        check("rand_run_cnt", got_word(170), 32'(k));
        #1 check("rand_run_enables", 32'(en_cnt), 32'(m_cycles));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
